ibex_prefetch_queue: RTL and testbench
======================================

# ibex_prefetch_queue

Parametrised instruction prefetch queue between the instruction-memory response path and the ID-stage instruction handoff in the ibex prefetch buffer. It buffers fetched 32-bit words and realigns 16-bit compressed and 32-bit instructions across word boundaries. It also tracks the current/next instruction PC. Relative to the fixed fetch FIFO, depth is decoupled from outstanding requests, and free-credit, occupancy and overflow-detection outputs are added.

## Interface
- NUM_REQS, 2, max outstanding memory requests; ≥1
- DEPTH, NUM_REQS+1, word entries; must satisfy DEPTH ≥ NUM_REQS+1 (elaboration error otherwise)
- CW (localparam), $clog2(DEPTH+1), count/credit width
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- clear_i  in  1  flush all entries; load PC from in_addr_i
- in_valid_i  in  1  response word valid (no back-pressure)
- in_addr_i  in  32  redirect PC, sampled only with clear_i; bit 0 ignored
- in_rdata_i  in  32  response word
- in_err_i  in  1  response bus error
- out_valid_o  out  1  complete instruction available
- out_ready_i  in  1  consumer accepts
- out_addr_o  out  32  PC of presented instruction, bit 0 = 0
- out_addr_next_o  out  32  PC after presented instruction
- out_rdata_o  out  32  realigned instruction; upper half don't-care if compressed
- out_err_o  out  1  instruction touches an errored word
- out_err_plus2_o  out  1  error only in second halfword of an unaligned instruction
- busy_o  out  NUM_REQS  valid flags of entries DEPTH-1 down to DEPTH-NUM_REQS
- count_o  out  CW  valid entries
- credit_o  out  CW  DEPTH − count_o
- overflow_o  out  1  sticky: response arrived while full and not popping

## Operation
- Shift queue: entry 0 is oldest. Valid flags are contiguous from 0. A push writes the lowest free entry. On a pop, entries shift down by one and a simultaneous push lands at the post-shift lowest free slot.
- Bypass: if entry 0 is invalid, in_rdata_i/in_err_i act as word 0. If entry 1 is invalid, in_rdata_i acts as word 1.
- Compressed test: halfword[1:0] ≠ 2'b11 and the source word is not errored.
- Aligned (PC[1]=0):
  - out_rdata_o = word0.
  - out_valid_o = entry0 valid | in_valid_i.
  - out_err_o = err0.
  - out_err_plus2_o = 0.
- Unaligned (PC[1]=1):
  - out_rdata_o = {word1[15:0], word0[31:16]}.
  - If compressed, valid = word0 available. Otherwise valid = word0 and word1 both available.
  - out_err_o = err0 | (err1 & ~compressed).
  - out_err_plus2_o = err1 & ~err0 & ~compressed.
- Pop on handshake (out_valid_o & out_ready_i) when the instruction ends at word0's upper boundary:
  - unaligned, any size; or
  - aligned and uncompressed.
- PC register is 31 bits [31:1]. On handshake it advances by +1 halfword if compressed, else +2 halfwords. Wraps modulo 2^32 with no flag.
- PC loads in_addr_i[31:1] on clear_i.
- out_addr_next_o = PC + increment, combinational.
- Overflow: in_valid_i with count = DEPTH and no pop → word dropped, overflow_o set. overflow_o clears on clear_i or reset.

## Timing
- Reset:
  - all valid flags 0; count_o 0; credit_o DEPTH; busy_o 0.
  - overflow_o 0; out_valid_o 0 (absent in_valid_i); PC 0.
  - Data/err regs are not reset.
- Bypass latency is 0: in_valid_i can give out_valid_o in the same cycle. A pushed word is visible from entry regs on the next cycle.
- out_* signals are combinational from state and inputs. Consumer must hold out_ready_i only as a qualifier; there is no requirement for valid to stay stable after a flush.
- clear_i has priority over everything:
  - next cycle all valid = 0 and PC = in_addr_i.
  - a same-cycle in_valid_i word is discarded.
  - a same-cycle handshake does not advance PC.
- Push + pop in the same cycle: count unchanged. Full + pop + push: accepted, no overflow.
- Reset asserted mid-operation: state clears immediately (asynchronous). Outputs follow the reset values above.

## Structure
- Shared package ibex_pkg:
  - constant IBEX_HALFWORD_W = 16.
  - function for the compressed test (is_compressed(hw, err)).
- Sub-module ibex_fetch_align (combinational): takes word0/word1/errs/valids and PC[1], and produces out_rdata/err/err_plus2/valid, compressed and pop_req.
- The queue registers, PC register and counters stay in the top module.

## Test plan
- Reset, DEPTH=3:
  - count_o=0, credit_o=3, busy_o=2'b00, out_valid_o=0.
  - One in_valid_i word 0x0000_0013 with out_ready_i=1 at PC 0 → same-cycle out_valid_o=1, out_rdata_o=0x13, out_addr_next_o=4, no entry stored.
- Two compressed halfwords: word 0x4501_4481 at PC 0x100 → two handshakes give out_rdata_o[15:0] 0x4481 then 0x4501. PCs are 0x100 and 0x102. Pop occurs on the second handshake only.
- Unaligned uncompressed: clear_i with in_addr_i 0x202; words 0x0013_xxxx then 0xxxxx_0000 → out_rdata_o=0x0000_0013 only after the second word arrives. out_addr_next_o=0x206.
- Error split: unaligned uncompressed with word0 clean and word1 in_err_i=1 → out_err_o=1, out_err_plus2_o=1. With word0 errored instead → out_err_plus2_o=0.
- Fill to DEPTH with out_ready_i=0, then one more in_valid_i:
  - overflow_o=1, count_o stays DEPTH, busy_o all ones.
  - clear_i → overflow_o=0, count_o=0.
- NUM_REQS=4, DEPTH=8: push 8 words while popping every other cycle → count_o/credit_o track exactly and never overflow. Simultaneous clear_i+in_valid_i leaves count_o=0.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared ibex constants and the compressed-instruction test.
package ibex_pkg;

  localparam int IBEX_HALFWORD_W = 16;

  // A halfword starts a compressed instruction unless its low bits are 2'b11.
  // An errored source word is always treated as a full 32-bit instruction.
  function automatic logic is_compressed(input logic [IBEX_HALFWORD_W-1:0] hw,
                                         input logic                       err);
    return (hw[1:0] != 2'b11) && !err;
  endfunction

endpackage

// File: rtl/ibex_prefetch_queue_if.sv
// Response-in / instruction-out bundle of the prefetch queue, plus status.
interface ibex_prefetch_queue_if #(
  parameter int NUM_REQS = 2,
  parameter int DEPTH    = NUM_REQS + 1
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                clear_i;
  logic                in_valid_i;
  logic [31:0]         in_addr_i;
  logic [31:0]         in_rdata_i;
  logic                in_err_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [31:0]         out_addr_o;
  logic [31:0]         out_addr_next_o;
  logic [31:0]         out_rdata_o;
  logic                out_err_o;
  logic                out_err_plus2_o;
  logic [NUM_REQS-1:0] busy_o;
  logic [CW-1:0]       count_o;
  logic [CW-1:0]       credit_o;
  logic                overflow_o;

  // Queue side
  modport slave (
    input  clear_i, in_valid_i, in_addr_i, in_rdata_i, in_err_i, out_ready_i,
    output out_valid_o, out_addr_o, out_addr_next_o, out_rdata_o, out_err_o,
    output out_err_plus2_o, busy_o, count_o, credit_o, overflow_o
  );

  // Fetch controller / consumer side
  modport master (
    output clear_i, in_valid_i, in_addr_i, in_rdata_i, in_err_i, out_ready_i,
    input  out_valid_o, out_addr_o, out_addr_next_o, out_rdata_o, out_err_o,
    input  out_err_plus2_o, busy_o, count_o, credit_o, overflow_o
  );

endinterface

// File: rtl/ibex_fetch_align.sv
// Combinational realignment of one instruction out of the two oldest words.
module ibex_fetch_align
  import ibex_pkg::*;
(
  input  logic [31:0] word0_i,
  input  logic [31:0] word1_i,
  input  logic        err0_i,
  input  logic        err1_i,
  input  logic        valid0_i,
  input  logic        valid1_i,
  input  logic        pc_hw_i,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        err_plus2_o,
  output logic        valid_o,
  output logic        compressed_o,
  output logic        pop_req_o
);

  logic [IBEX_HALFWORD_W-1:0] first_hw;
  logic [15:0]                unused_word1_hi;

  assign unused_word1_hi = word1_i[31:16];
  assign first_hw        = pc_hw_i ? word0_i[31:16] : word0_i[15:0];

  // Select instruction halves and qualify valid/error by alignment and size.
  always_comb begin
    compressed_o = is_compressed(first_hw, err0_i);
    rdata_o      = word0_i;
    valid_o      = valid0_i;
    err_o        = err0_i;
    err_plus2_o  = 1'b0;
    if (pc_hw_i) begin
      rdata_o     = {word1_i[15:0], word0_i[31:16]};
      valid_o     = compressed_o ? valid0_i : (valid0_i & valid1_i);
      err_o       = err0_i | (err1_i & ~compressed_o);
      err_plus2_o = err1_i & ~err0_i & ~compressed_o;
    end
    // word0 is exhausted once the instruction reaches its upper boundary
    pop_req_o = pc_hw_i | ~compressed_o;
  end

endmodule

// File: rtl/ibex_prefetch_queue.sv
// Shift-register fetch queue with bypass, PC tracking and credit/overflow status.
module ibex_prefetch_queue
  import ibex_pkg::*;
#(
  parameter int NUM_REQS = 2,
  parameter int DEPTH    = NUM_REQS + 1
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  ibex_prefetch_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  if (NUM_REQS < 1 || DEPTH < NUM_REQS + 1) begin : g_param_err
    $error("ibex_prefetch_queue: need NUM_REQS >= 1 and DEPTH >= NUM_REQS+1");
  end

  logic [31:0]      rdata_q [DEPTH];
  logic             err_q   [DEPTH];
  logic [CW-1:0]    count_q, count_d, wr_idx;
  logic [31:1]      pc_q, pc_d;
  logic             overflow_q;
  logic [DEPTH-1:0] valid;
  logic             full, push, pop, store_push, handshake, overflow_set;
  logic             out_valid, compressed, pop_req;
  logic [31:0]      word0, word1;
  logic             err0, err1, valid0, valid1;
  logic             unused_addr0;

  assign unused_addr0 = bus.in_addr_i[0];

  // Valid flags are contiguous from entry 0, so the count fully describes them.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    assign valid[gi] = (count_q > CW'(gi));
  end

  // Missing entries are bypassed from the incoming response word.
  assign word0  = valid[0] ? rdata_q[0] : bus.in_rdata_i;
  assign err0   = valid[0] ? err_q[0]   : bus.in_err_i;
  assign valid0 = valid[0] | bus.in_valid_i;
  assign word1  = valid[1] ? rdata_q[1] : bus.in_rdata_i;
  assign err1   = valid[1] ? err_q[1]   : bus.in_err_i;
  assign valid1 = valid[1] | (valid[0] & bus.in_valid_i);

  ibex_fetch_align u_align (
    .word0_i      (word0),
    .word1_i      (word1),
    .err0_i       (err0),
    .err1_i       (err1),
    .valid0_i     (valid0),
    .valid1_i     (valid1),
    .pc_hw_i      (pc_q[1]),
    .rdata_o      (bus.out_rdata_o),
    .err_o        (bus.out_err_o),
    .err_plus2_o  (bus.out_err_plus2_o),
    .valid_o      (out_valid),
    .compressed_o (compressed),
    .pop_req_o    (pop_req)
  );

  assign handshake    = out_valid & bus.out_ready_i;
  assign pop          = handshake & pop_req;
  assign full         = (count_q == CW'(DEPTH));
  assign push         = bus.in_valid_i & (~full | pop);
  // An empty-queue pop consumes the bypassed word itself, so nothing is stored.
  assign store_push   = push & ~(pop & (count_q == '0));
  assign wr_idx       = pop ? (count_q - CW'(1)) : count_q;
  assign count_d      = count_q + CW'(push) - CW'(pop);
  assign overflow_set = bus.in_valid_i & full & ~pop;
  assign pc_d         = pc_q + (compressed ? 31'd1 : 31'd2);

  assign bus.out_valid_o     = out_valid;
  assign bus.out_addr_o      = {pc_q, 1'b0};
  assign bus.out_addr_next_o = {pc_d, 1'b0};
  assign bus.count_o         = count_q;
  assign bus.credit_o        = CW'(DEPTH) - count_q;
  assign bus.overflow_o      = overflow_q;

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_busy
    assign bus.busy_o[gi] = valid[DEPTH-NUM_REQS+gi];
  end

  // Occupancy, PC and sticky overflow; a flush overrides every other update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      pc_q       <= '0;
      overflow_q <= 1'b0;
    end else if (bus.clear_i) begin
      count_q    <= '0;
      pc_q       <= bus.in_addr_i[31:1];
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (handshake)    pc_q       <= pc_d;
      if (overflow_set) overflow_q <= 1'b1;
    end
  end

  // Entry payloads are not reset; validity comes only from the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    if (gi < DEPTH - 1) begin : g_mid
      // Load the incoming word at the write slot, otherwise shift down on a pop.
      always_ff @(posedge clk_i) begin
        if (store_push && wr_idx == CW'(gi)) begin
          rdata_q[gi] <= bus.in_rdata_i;
          err_q[gi]   <= bus.in_err_i;
        end else if (pop) begin
          rdata_q[gi] <= rdata_q[gi+1];
          err_q[gi]   <= err_q[gi+1];
        end
      end
    end else begin : g_top
      // The top entry only ever receives new words.
      always_ff @(posedge clk_i) begin
        if (store_push && wr_idx == CW'(gi)) begin
          rdata_q[gi] <= bus.in_rdata_i;
          err_q[gi]   <= bus.in_err_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_ibex_prefetch_queue.sv
// Directed, table-driven bench for ibex_prefetch_queue (DEPTH=3 and DEPTH=8 instances).
module tb_ibex_prefetch_queue;

  logic clk_i = 1'b0;
  logic rst_ni;

  always #5 clk_i = ~clk_i;

  ibex_prefetch_queue_if #(.NUM_REQS(2), .DEPTH(3)) bus_a ();
  ibex_prefetch_queue_if #(.NUM_REQS(4), .DEPTH(8)) bus_b ();

  ibex_prefetch_queue #(.NUM_REQS(2), .DEPTH(3)) dut_a (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus_a)
  );

  ibex_prefetch_queue #(.NUM_REQS(4), .DEPTH(8)) dut_b (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus_b)
  );

  typedef struct {
    logic        clr;
    logic        iv;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    logic        rdy;
    logic        ev;
    logic [31:0] erd;
    logic [31:0] emask;
    logic [31:0] eaddr;
    logic [31:0] enext;
    logic        eerr;
    logic        ep2;
    int          ecnt;
    logic        eovf;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic clr, input logic iv, input logic [31:0] addr,
                              input logic [31:0] rdata, input logic err, input logic rdy,
                              input logic ev, input logic [31:0] erd, input logic [31:0] emask,
                              input logic [31:0] eaddr, input logic [31:0] enext,
                              input logic eerr, input logic ep2, input int ecnt,
                              input logic eovf);
    vec_t v;
    v.clr = clr; v.iv = iv; v.addr = addr; v.rdata = rdata; v.err = err; v.rdy = rdy;
    v.ev = ev; v.erd = erd; v.emask = emask; v.eaddr = eaddr; v.enext = enext;
    v.eerr = eerr; v.ep2 = ep2; v.ecnt = ecnt; v.eovf = eovf;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h", nm, idx, act, exp);
    end
  endtask

  task automatic idle_a();
    bus_a.clear_i = 0; bus_a.in_valid_i = 0; bus_a.in_addr_i = 0;
    bus_a.in_rdata_i = 0; bus_a.in_err_i = 0; bus_a.out_ready_i = 0;
  endtask

  task automatic idle_b();
    bus_b.clear_i = 0; bus_b.in_valid_i = 0; bus_b.in_addr_i = 0;
    bus_b.in_rdata_i = 0; bus_b.in_err_i = 0; bus_b.out_ready_i = 0;
  endtask

  // Busy flags for DEPTH=3 / NUM_REQS=2 cover entries 2 and 1.
  function automatic logic [31:0] busy_a_of(input int c);
    return {30'd0, c >= 3, c >= 2};
  endfunction

  initial begin
    logic [31:0] q [$];
    logic [31:0] w;
    int          guard;

    // ---------------- vector table (DEPTH=3) ----------------
    //             clr iv addr          rdata         err rdy ev  erd           emask         eaddr         enext         eerr ep2 cnt ovf
    vecs[0]  = mk(0, 1, 32'h0,        32'h0000_0013, 0, 1,  1, 32'h0000_0013, 32'hFFFF_FFFF, 32'h0,     32'h4,     0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0,        32'h0,         0, 0,  0, 32'h0,         32'h0,         32'h4,     32'h6,     0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 32'h100,      32'hDEAD_BEEF, 0, 1,  1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h4,     32'h8,     0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 32'h0,        32'h4501_4481, 0, 1,  1, 32'h0000_4481, 32'h0000_FFFF, 32'h100,   32'h102,   0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 32'h0,        32'h0,         0, 1,  1, 32'h0000_4501, 32'h0000_FFFF, 32'h102,   32'h104,   0, 0, 1, 0);
    vecs[5]  = mk(0, 0, 32'h0,        32'h0,         0, 0,  0, 32'h0,         32'h0,         32'h104,   32'h106,   0, 0, 0, 0);
    vecs[6]  = mk(1, 0, 32'h202,      32'h0,         0, 0,  0, 32'h0,         32'h0,         32'h104,   32'h106,   0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 32'h0,        32'h0013_ABCD, 0, 1,  0, 32'h0,         32'h0,         32'h202,   32'h206,   0, 0, 0, 0);
    vecs[8]  = mk(0, 1, 32'h0,        32'h5555_0000, 0, 1,  1, 32'h0000_0013, 32'hFFFF_FFFF, 32'h202,   32'h206,   0, 0, 1, 0);
    vecs[9]  = mk(0, 0, 32'h0,        32'h0,         0, 0,  1, 32'h0000_5555, 32'h0000_FFFF, 32'h206,   32'h208,   0, 0, 1, 0);
    vecs[10] = mk(1, 0, 32'h302,      32'h0,         0, 0,  1, 32'h0000_5555, 32'h0000_FFFF, 32'h206,   32'h208,   0, 0, 1, 0);
    vecs[11] = mk(0, 1, 32'h0,        32'h0003_0000, 0, 0,  0, 32'h0,         32'h0,         32'h302,   32'h306,   0, 0, 0, 0);
    vecs[12] = mk(0, 1, 32'h0,        32'h0000_0000, 1, 1,  1, 32'h0000_0003, 32'hFFFF_FFFF, 32'h302,   32'h306,   1, 1, 1, 0);
    vecs[13] = mk(0, 1, 32'h0,        32'hFFFF_FFFF, 0, 1,  1, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h306,   32'h30A,   1, 0, 1, 0);
    vecs[14] = mk(1, 0, 32'h0,        32'h0,         0, 0,  0, 32'h0,         32'h0,         32'h30A,   32'h30E,   0, 0, 1, 0);
    vecs[15] = mk(0, 1, 32'h0,        32'hA000_0003, 0, 0,  1, 32'hA000_0003, 32'hFFFF_FFFF, 32'h0,     32'h4,     0, 0, 0, 0);
    vecs[16] = mk(0, 1, 32'h0,        32'hB000_0003, 0, 0,  1, 32'hA000_0003, 32'hFFFF_FFFF, 32'h0,     32'h4,     0, 0, 1, 0);
    vecs[17] = mk(0, 1, 32'h0,        32'hC000_0003, 0, 0,  1, 32'hA000_0003, 32'hFFFF_FFFF, 32'h0,     32'h4,     0, 0, 2, 0);
    vecs[18] = mk(0, 1, 32'h0,        32'hD000_0003, 0, 0,  1, 32'hA000_0003, 32'hFFFF_FFFF, 32'h0,     32'h4,     0, 0, 3, 0);
    vecs[19] = mk(0, 0, 32'h0,        32'h0,         0, 0,  1, 32'hA000_0003, 32'hFFFF_FFFF, 32'h0,     32'h4,     0, 0, 3, 1);
    vecs[20] = mk(1, 1, 32'h0,        32'hE000_0003, 0, 0,  1, 32'hA000_0003, 32'hFFFF_FFFF, 32'h0,     32'h4,     0, 0, 3, 1);
    vecs[21] = mk(0, 0, 32'h0,        32'h0,         0, 0,  0, 32'h0,         32'h0,         32'h0,     32'h2,     0, 0, 0, 0);
    vecs[22] = mk(0, 1, 32'h0,        32'hA000_0003, 0, 0,  1, 32'hA000_0003, 32'hFFFF_FFFF, 32'h0,     32'h4,     0, 0, 0, 0);
    vecs[23] = mk(0, 1, 32'h0,        32'hB000_0003, 0, 0,  1, 32'hA000_0003, 32'hFFFF_FFFF, 32'h0,     32'h4,     0, 0, 1, 0);
    vecs[24] = mk(0, 1, 32'h0,        32'hC000_0003, 0, 0,  1, 32'hA000_0003, 32'hFFFF_FFFF, 32'h0,     32'h4,     0, 0, 2, 0);
    vecs[25] = mk(0, 1, 32'h0,        32'hD000_0003, 0, 1,  1, 32'hA000_0003, 32'hFFFF_FFFF, 32'h0,     32'h4,     0, 0, 3, 0);
    vecs[26] = mk(0, 0, 32'h0,        32'h0,         0, 1,  1, 32'hB000_0003, 32'hFFFF_FFFF, 32'h4,     32'h8,     0, 0, 3, 0);
    vecs[27] = mk(0, 0, 32'h0,        32'h0,         0, 0,  1, 32'hC000_0003, 32'hFFFF_FFFF, 32'h8,     32'hC,     0, 0, 2, 0);

    // ---------------- reset state ----------------
    rst_ni = 1'b0;
    idle_a();
    idle_b();
    #12;
    n_vec++;
    chk("rst_a_count",  0, 32'(bus_a.count_o),  32'd0);
    chk("rst_a_credit", 0, 32'(bus_a.credit_o), 32'd3);
    chk("rst_a_busy",   0, 32'(bus_a.busy_o),   32'd0);
    chk("rst_a_valid",  0, 32'(bus_a.out_valid_o), 32'd0);
    chk("rst_a_ovf",    0, 32'(bus_a.overflow_o),  32'd0);
    chk("rst_a_addr",   0, bus_a.out_addr_o,    32'd0);
    chk("rst_b_count",  0, 32'(bus_b.count_o),  32'd0);
    chk("rst_b_credit", 0, 32'(bus_b.credit_o), 32'd8);
    chk("rst_b_busy",   0, 32'(bus_b.busy_o),   32'd0);
    $display("reset: count_a=%0d credit_a=%0d credit_b=%0d", bus_a.count_o, bus_a.credit_o, bus_b.credit_o);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      bus_a.clear_i     = vecs[i].clr;
      bus_a.in_valid_i  = vecs[i].iv;
      bus_a.in_addr_i   = vecs[i].addr;
      bus_a.in_rdata_i  = vecs[i].rdata;
      bus_a.in_err_i    = vecs[i].err;
      bus_a.out_ready_i = vecs[i].rdy;
      #1;
      n_vec++;
      chk("valid",  i, 32'(bus_a.out_valid_o), 32'(vecs[i].ev));
      chk("rdata",  i, bus_a.out_rdata_o & vecs[i].emask, vecs[i].erd);
      chk("addr",   i, bus_a.out_addr_o, vecs[i].eaddr);
      chk("next",   i, bus_a.out_addr_next_o, vecs[i].enext);
      chk("err",    i, 32'(bus_a.out_err_o), 32'(vecs[i].eerr));
      chk("plus2",  i, 32'(bus_a.out_err_plus2_o), 32'(vecs[i].ep2));
      chk("count",  i, 32'(bus_a.count_o), 32'(vecs[i].ecnt));
      chk("credit", i, 32'(bus_a.credit_o), 32'(3 - vecs[i].ecnt));
      chk("busy",   i, 32'(bus_a.busy_o), busy_a_of(vecs[i].ecnt));
      chk("ovf",    i, 32'(bus_a.overflow_o), 32'(vecs[i].eovf));
      $display("vec %0d: valid=%0b rdata=%08h addr=%08h next=%08h count=%0d ovf=%0b",
               i, bus_a.out_valid_o, bus_a.out_rdata_o, bus_a.out_addr_o,
               bus_a.out_addr_next_o, bus_a.count_o, bus_a.overflow_o);
    end

    // ---------------- asynchronous reset mid-operation (count=2 here) ----------------
    @(negedge clk_i);
    idle_a();
    #2;
    rst_ni = 1'b0;
    #1;
    n_vec++;
    chk("mid_rst_count",  0, 32'(bus_a.count_o),  32'd0);
    chk("mid_rst_credit", 0, 32'(bus_a.credit_o), 32'd3);
    chk("mid_rst_valid",  0, 32'(bus_a.out_valid_o), 32'd0);
    chk("mid_rst_addr",   0, bus_a.out_addr_o, 32'd0);
    $display("mid-reset: count=%0d valid=%0b", bus_a.count_o, bus_a.out_valid_o);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // ---------------- DEPTH=8: push 8 words, pop every other cycle ----------------
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      w = 32'h0000_0003 | (32'(i) << 8);
      bus_b.in_valid_i  = 1'b1;
      bus_b.in_rdata_i  = w;
      bus_b.out_ready_i = i[0];
      #1;
      n_vec++;
      chk("b_fill_count",  i, 32'(bus_b.count_o),  32'(q.size()));
      chk("b_fill_credit", i, 32'(bus_b.credit_o), 32'(8 - q.size()));
      q.push_back(w);
      chk("b_fill_valid",  i, 32'(bus_b.out_valid_o), 32'd1);
      chk("b_fill_rdata",  i, bus_b.out_rdata_o, q[0]);
      chk("b_fill_ovf",    i, 32'(bus_b.overflow_o), 32'd0);
      $display("b fill %0d: in=%08h rdy=%0b out=%08h count=%0d credit=%0d",
               i, w, bus_b.out_ready_i, bus_b.out_rdata_o, bus_b.count_o, bus_b.credit_o);
      if (i[0]) void'(q.pop_front());
    end

    // Drain what is left, bounded by a fixed cycle budget.
    guard = 0;
    while (q.size() > 0 && guard < 16) begin
      @(negedge clk_i);
      idle_b();
      bus_b.out_ready_i = 1'b1;
      #1;
      n_vec++;
      chk("b_drain_count", guard, 32'(bus_b.count_o), 32'(q.size()));
      chk("b_drain_valid", guard, 32'(bus_b.out_valid_o), 32'd1);
      chk("b_drain_rdata", guard, bus_b.out_rdata_o, q[0]);
      chk("b_drain_ovf",   guard, 32'(bus_b.overflow_o), 32'd0);
      $display("b drain %0d: out=%08h count=%0d", guard, bus_b.out_rdata_o, bus_b.count_o);
      void'(q.pop_front());
      guard++;
    end
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL b_drain_budget: %0d words left, expected 0", q.size());
    end

    @(negedge clk_i);
    idle_b();
    #1;
    n_vec++;
    chk("b_empty_count",  0, 32'(bus_b.count_o),  32'd0);
    chk("b_empty_credit", 0, 32'(bus_b.credit_o), 32'd8);
    chk("b_empty_valid",  0, 32'(bus_b.out_valid_o), 32'd0);
    $display("b empty: count=%0d credit=%0d", bus_b.count_o, bus_b.credit_o);

    // Simultaneous clear and response word: the word must be discarded.
    @(negedge clk_i);
    bus_b.clear_i    = 1'b1;
    bus_b.in_valid_i = 1'b1;
    bus_b.in_addr_i  = 32'h0000_0400;
    bus_b.in_rdata_i = 32'h1234_5673;
    @(negedge clk_i);
    idle_b();
    #1;
    n_vec++;
    chk("b_clr_count", 0, 32'(bus_b.count_o), 32'd0);
    chk("b_clr_addr",  0, bus_b.out_addr_o, 32'h0000_0400);
    chk("b_clr_valid", 0, 32'(bus_b.out_valid_o), 32'd0);
    $display("b clear+push: count=%0d addr=%08h", bus_b.count_o, bus_b.out_addr_o);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
